dram_write: RTL and testbench

- Write-side controller for the external asynchronous 32-bit SRAM. This is the writer counterpart to the instruction-ROM read controller.
- Accepts a single-word write request (address, data, byte select) from the memory stage.
- Sequences the active-low SRAM strobes through setup, write-pulse and hold phases, and drives the bidirectional data bus only while a write is in flight.
- Asserts a one-cycle completion pulse so the pipeline can release its stall.

---
 rtl/dram_write_if.sv | 28 ++
 rtl/dram_write.sv | 117 +++++++++++
 tb/tb_dram_write.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_write_if.sv
// Request and SRAM-side signal bundle for the dram_write controller.
// The slave modport is the controller; the master modport is the memory stage plus SRAM pins.
interface dram_write_if;
  logic        write_ce;
  logic [19:0] address;
  logic [31:0] wdata;
  logic [3:0]  byte_sel;
  logic        ready;
  logic        busy;
  logic [19:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        data_oe;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;
  logic [3:0]  be_n;
  logic        wfin;

  modport slave (
    input  write_ce, address, wdata, byte_sel,
    output ready, busy, ram_addr, ram_wdata, data_oe, ce_n, oe_n, we_n, be_n, wfin
  );

  modport master (
    output write_ce, address, wdata, byte_sel,
    input  ready, busy, ram_addr, ram_wdata, data_oe, ce_n, oe_n, we_n, be_n, wfin
  );
endinterface

// File: rtl/dram_write.sv
// Write-side controller for the external asynchronous 32-bit SRAM: latches one word request
// and walks the active-low strobes through setup, write-pulse and hold phases.
module dram_write #(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input logic         clk,
  input logic         rst,
  dram_write_if.slave bus
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 7) begin : g_bad_setup
    $error("dram_write: SETUP_CYCLES must be in 1..7");
  end
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 7) begin : g_bad_pulse
    $error("dram_write: PULSE_CYCLES must be in 1..7");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 7) begin : g_bad_hold
    $error("dram_write: HOLD_CYCLES must be in 1..7");
  end

  localparam logic [2:0] SETUP_LAST = 3'(SETUP_CYCLES - 1);
  localparam logic [2:0] PULSE_LAST = 3'(PULSE_CYCLES - 1);
  localparam logic [2:0] HOLD_LAST  = 3'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        last_hold;
  logic        accept;
  logic [19:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A request can be taken in IDLE or in the final HOLD cycle, which gives back-to-back writes.
  always_comb begin
    last_hold = (state == HOLD) && (cnt == HOLD_LAST);
    accept    = ((state == IDLE) || last_hold) && bus.write_ce;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 3'd1;
    unique case (state)
      IDLE: begin
        cnt_nxt = 3'd0;
        if (bus.write_ce) state_nxt = SETUP;
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = PULSE;
          cnt_nxt   = 3'd0;
        end
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = 3'd0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = bus.write_ce ? SETUP : IDLE;
          cnt_nxt   = 3'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 20'd0;
      wdata_q <= 32'd0;
      be_n_q  <= 4'b1111;
    end else if (accept) begin
      addr_q  <= bus.address;
      wdata_q <= bus.wdata;
      be_n_q  <= ~bus.byte_sel;
    end
  end

  // Strobes decode from the state register alone, so an async reset releases them at once.
  always_comb begin
    bus.ce_n      = (state == IDLE);
    bus.we_n      = (state != PULSE);
    bus.data_oe   = (state != IDLE);
    bus.oe_n      = 1'b1;
    bus.busy      = (state != IDLE);
    bus.wfin      = last_hold;
    bus.ready     = (state == IDLE) || last_hold;
    bus.ram_addr  = addr_q;
    bus.ram_wdata = wdata_q;
    bus.be_n      = be_n_q;
  end

endmodule

// File: tb/tb_dram_write.sv
// Directed self-checking bench for dram_write: default timing instance plus a 2/3/2 timing instance.
module tb_dram_write;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dram_write_if bus ();
  dram_write_if bus6 ();

  dram_write u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dram_write #(
    .SETUP_CYCLES (2),
    .PULSE_CYCLES (3),
    .HOLD_CYCLES  (2)
  ) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  int n_vec = 0;
  int n_err = 0;

  // Status bundle: {ce_n, we_n, data_oe, wfin, ready, busy}
  function automatic logic [5:0] st_main();
    return {bus.ce_n, bus.we_n, bus.data_oe, bus.wfin, bus.ready, bus.busy};
  endfunction

  function automatic logic [5:0] st_six();
    return {bus6.ce_n, bus6.we_n, bus6.data_oe, bus6.wfin, bus6.ready, bus6.busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [19:0] a, input logic [31:0] d, input logic [3:0] bs);
    bus.write_ce = 1'b1;
    bus.address  = a;
    bus.wdata    = d;
    bus.byte_sel = bs;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (st_main() !== 6'b110010) begin
      n_err++;
      $display("[TB] FAIL reset status: got %b expected %b", st_main(), 6'b110010);
    end
    n_vec++;
    if ({bus.ram_addr, bus.ram_wdata, bus.be_n, bus.oe_n} !== {20'h0, 32'h0, 4'hF, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL reset regs: got %h %h %b %b expected 00000 00000000 1111 1",
               bus.ram_addr, bus.ram_wdata, bus.be_n, bus.oe_n);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (st_main() !== 6'b110010) begin
      n_err++;
      $display("[TB] FAIL post-reset status: got %b expected %b", st_main(), 6'b110010);
    end
  endtask

  task automatic test_single_write();
    logic [5:0] exp_st [5];
    exp_st = '{6'b011001, 6'b001001, 6'b001001, 6'b011111, 6'b110010};
    request(20'h00010, 32'hDEADBEEF, 4'hF);
    tick();
    bus.write_ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (st_main() !== exp_st[i]) begin
        n_err++;
        $display("[TB] FAIL single status c%0d: got %b expected %b", i + 1, st_main(), exp_st[i]);
      end
      if (i < 4) begin
        n_vec++;
        if ({bus.ram_addr, bus.ram_wdata, bus.be_n} !== {20'h00010, 32'hDEADBEEF, 4'h0}) begin
          n_err++;
          $display("[TB] FAIL single latch c%0d: got %h %h %b expected 00010 deadbeef 0000",
                   i + 1, bus.ram_addr, bus.ram_wdata, bus.be_n);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  exp_st [9];
    logic [19:0] exp_a  [8];
    logic [31:0] exp_d  [8];
    int nw;
    exp_st = '{6'b011001, 6'b001001, 6'b001001, 6'b011111,
               6'b011001, 6'b001001, 6'b001001, 6'b011111, 6'b110010};
    exp_a  = '{20'h1, 20'h1, 20'h1, 20'h1, 20'h2, 20'h2, 20'h2, 20'h2};
    exp_d  = '{32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111,
               32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222};
    nw = 0;
    request(20'h1, 32'h11111111, 4'hF);
    tick();
    request(20'h2, 32'h22222222, 4'hF);
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (st_main() !== exp_st[i]) begin
        n_err++;
        $display("[TB] FAIL b2b status c%0d: got %b expected %b", i + 1, st_main(), exp_st[i]);
      end
      if (i < 8) begin
        n_vec++;
        if ({bus.ram_addr, bus.ram_wdata} !== {exp_a[i], exp_d[i]}) begin
          n_err++;
          $display("[TB] FAIL b2b latch c%0d: got %h %h expected %h %h",
                   i + 1, bus.ram_addr, bus.ram_wdata, exp_a[i], exp_d[i]);
        end
      end
      nw += int'(bus.wfin);
      if (i == 4) bus.write_ce = 1'b0;
      tick();
    end
    n_vec++;
    if (nw !== 2) begin
      n_err++;
      $display("[TB] FAIL b2b wfin count: got %0d expected 2", nw);
    end
  endtask

  task automatic test_byte_select();
    logic [3:0] bs_tab [2];
    logic [3:0] be_tab [2];
    int nw;
    bs_tab = '{4'b0101, 4'b0000};
    be_tab = '{4'b1010, 4'b1111};
    for (int r = 0; r < 2; r++) begin
      nw = 0;
      request(20'h00055, 32'hA5A5A5A5, bs_tab[r]);
      tick();
      bus.write_ce = 1'b0;
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (bus.be_n !== be_tab[r]) begin
          n_err++;
          $display("[TB] FAIL be_n run%0d c%0d: got %b expected %b", r, i + 1, bus.be_n, be_tab[r]);
        end
        nw += int'(bus.wfin);
        tick();
      end
      n_vec++;
      if (nw !== 1 || st_main() !== 6'b110010) begin
        n_err++;
        $display("[TB] FAIL be_n run%0d end: wfin count %0d status %b expected 1 110010",
                 r, nw, st_main());
      end
    end
  endtask

  task automatic test_ignore_during_pulse();
    logic [5:0] exp_st [4];
    int nw;
    exp_st = '{6'b001001, 6'b011111, 6'b110010, 6'b110010};
    nw = 0;
    request(20'h00030, 32'h30303030, 4'hF);
    tick();
    bus.write_ce = 1'b0;
    tick();
    request(20'h00040, 32'h40404040, 4'hF);
    tick();
    bus.write_ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (st_main() !== exp_st[i] || bus.ram_addr !== 20'h00030) begin
        n_err++;
        $display("[TB] FAIL ignore c%0d: got status %b addr %h expected %b 00030",
                 i + 3, st_main(), bus.ram_addr, exp_st[i]);
      end
      nw += int'(bus.wfin);
      tick();
    end
    n_vec++;
    if (nw !== 1) begin
      n_err++;
      $display("[TB] FAIL ignore wfin count: got %0d expected 1", nw);
    end
  endtask

  task automatic test_reset_mid_write();
    request(20'h00077, 32'h77777777, 4'h3);
    tick();
    bus.write_ce = 1'b0;
    tick();
    tick();
    n_vec++;
    if (st_main() !== 6'b001001) begin
      n_err++;
      $display("[TB] FAIL midrst pulse2: got %b expected %b", st_main(), 6'b001001);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (st_main() !== 6'b110010 || bus.ram_addr !== 20'h0) begin
      n_err++;
      $display("[TB] FAIL midrst abort: got status %b addr %h expected 110010 00000",
               st_main(), bus.ram_addr);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (st_main() !== 6'b110010) begin
        n_err++;
        $display("[TB] FAIL midrst after c%0d: got %b expected %b", i + 1, st_main(), 6'b110010);
      end
    end
  endtask

  task automatic test_long_params();
    logic [5:0] exp_st [8];
    exp_st = '{6'b011001, 6'b011001, 6'b001001, 6'b001001, 6'b001001,
               6'b011001, 6'b011111, 6'b110010};
    bus6.write_ce = 1'b1;
    bus6.address  = 20'h00123;
    bus6.wdata    = 32'hCAFEF00D;
    bus6.byte_sel = 4'hF;
    tick();
    bus6.write_ce = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (st_six() !== exp_st[i]) begin
        n_err++;
        $display("[TB] FAIL long status c%0d: got %b expected %b", i + 1, st_six(), exp_st[i]);
      end
      if (i < 7) begin
        n_vec++;
        if ({bus6.ram_addr, bus6.ram_wdata} !== {20'h00123, 32'hCAFEF00D}) begin
          n_err++;
          $display("[TB] FAIL long latch c%0d: got %h %h expected 00123 cafef00d",
                   i + 1, bus6.ram_addr, bus6.ram_wdata);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.write_ce  = 1'b0;
    bus.address   = 20'h0;
    bus.wdata     = 32'h0;
    bus.byte_sel  = 4'h0;
    bus6.write_ce = 1'b0;
    bus6.address  = 20'h0;
    bus6.wdata    = 32'h0;
    bus6.byte_sel = 4'h0;
    $display("[TB] starting dram_write directed tests");
    test_reset();
    test_single_write();
    test_back_to_back();
    test_byte_select();
    test_ignore_during_pulse();
    test_reset_mid_write();
    test_long_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
